// File: rtl/mem_dispatcher_pkg.sv
// Shared encodings for the byte-serial memory dispatcher.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mem_dispatcher_pkg;

    // Dispatcher FSM states
    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_FETCH = 2'd1,
        MEM_LOAD  = 2'd2,
        MEM_STORE = 2'd3
    } mem_state_t;

    // LSB access size encodings
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // addr[17:16] value selecting the IO region (0x30000)
    localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

    // Number of bus bytes for an LSB size code; the unused code is treated as a word
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

    // Replace byte lane idx of a little-endian word
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/mem_dispatcher.sv
// Arbitrates fetcher and load/store buffer onto one byte-wide RAM/IO bus, serialising little-endian words.
// Latency: read of N bytes pulses N+1 edges after accept; store of N bytes pulses N edges after accept.
// Backpressure: req_enable low while busy or cooling; in_rdy low freezes everything; full UART buffer stalls IO stores.
module mem_dispatcher
    import mem_dispatcher_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_rdy,
    input  logic              in_flush_enable,
    input  logic              in_io_buffer_full,
    output logic [ADDR_W-1:0] out_mem_a,
    output logic [7:0]        out_mem_dout,
    output logic              out_mem_wr,
    input  logic [7:0]        in_mem_din,
    input  logic              in_pc_requesting,
    input  logic [ADDR_W-1:0] in_pc_addr,
    output logic              out_pc_req_enable,
    output logic              out_pc_data_enable,
    output logic [31:0]       out_pc_inst,
    input  logic              in_lsb_requesting,
    input  logic              in_lsb_rw,
    input  logic [1:0]        in_lsb_size,
    input  logic [ADDR_W-1:0] in_lsb_addr,
    input  logic [31:0]       in_lsb_wdata,
    output logic              out_lsb_req_enable,
    output logic              out_lsb_data_enable,
    output logic [31:0]       out_lsb_rdata
);

    mem_state_t        r_state;
    logic              r_cool;      // one idle cycle after completion/flush: fetcher's request level is stale
    logic [2:0]        r_cnt;       // reads: edges since accept minus one; stores: index of byte on the bus
    logic [2:0]        r_len;       // access length in bytes
    logic [31:0]       r_wdata;     // store bytes not yet placed on the bus, next one in [7:0]
    logic [31:0]       r_rbuf;      // read bytes assembled so far
    logic              r_wr;
    logic [ADDR_W-1:0] r_mem_a;
    logic [7:0]        r_mem_dout;
    logic              r_pc_de;
    logic              r_lsb_de;
    logic [31:0]       r_pc_inst;
    logic [31:0]       r_lsb_rdata;

    logic              w_idle_open;
    logic              w_io_stall;
    logic [1:0]        w_cap_idx;
    logic [31:0]       w_rbuf_next;

    assign w_idle_open = (r_state == MEM_IDLE) && !r_cool;
    // IO store waits while the UART cannot take another byte
    assign w_io_stall  = (r_state == MEM_STORE) && (r_mem_a[17:16] == IO_SEL) && in_io_buffer_full;
    // byte on in_mem_din belongs to the address driven one cycle earlier
    assign w_cap_idx   = 2'(r_cnt - 3'd1);
    assign w_rbuf_next = put_byte(r_rbuf, w_cap_idx, in_mem_din);

    assign out_mem_a           = r_mem_a;
    assign out_mem_dout        = r_mem_dout;
    // gated combinationally so a frozen or stalled cycle never repeats a write
    assign out_mem_wr          = r_wr && in_rdy && !w_io_stall;
    assign out_pc_req_enable   = w_idle_open;
    assign out_lsb_req_enable  = w_idle_open;
    assign out_pc_data_enable  = r_pc_de;
    assign out_pc_inst         = r_pc_inst;
    assign out_lsb_data_enable = r_lsb_de;
    assign out_lsb_rdata       = r_lsb_rdata;

    // Dispatcher FSM: arbitration, byte sequencing, data assembly and registered bus/client outputs
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state     <= MEM_IDLE;
            r_cool      <= 1'b0;
            r_cnt       <= 3'd0;
            r_len       <= 3'd0;
            r_wdata     <= 32'd0;
            r_rbuf      <= 32'd0;
            r_wr        <= 1'b0;
            r_mem_a     <= '0;
            r_mem_dout  <= 8'd0;
            r_pc_de     <= 1'b0;
            r_lsb_de    <= 1'b0;
            r_pc_inst   <= 32'd0;
            r_lsb_rdata <= 32'd0;
        end else if (in_rdy) begin
            r_pc_de  <= 1'b0;
            r_lsb_de <= 1'b0;
            case (r_state)
                MEM_IDLE: begin
                    // a flush restarts the cool period and blocks any same-cycle accept
                    r_cool <= in_flush_enable;
                    if (!in_flush_enable && !r_cool && (in_lsb_requesting || in_pc_requesting)) begin
                        r_cnt  <= 3'd0;
                        r_rbuf <= 32'd0;
                        if (in_lsb_requesting) begin
                            r_mem_a    <= in_lsb_addr;
                            r_len      <= size_bytes(in_lsb_size);
                            r_mem_dout <= in_lsb_wdata[7:0];
                            r_wdata    <= {8'd0, in_lsb_wdata[31:8]};
                            r_wr       <= in_lsb_rw;
                            r_state    <= in_lsb_rw ? MEM_STORE : MEM_LOAD;
                        end else begin
                            r_mem_a    <= in_pc_addr;
                            r_len      <= 3'd4;
                            r_mem_dout <= 8'd0;
                            r_wdata    <= 32'd0;
                            r_wr       <= 1'b0;
                            r_state    <= MEM_FETCH;
                        end
                    end
                end
                MEM_FETCH, MEM_LOAD: begin
                    if (in_flush_enable) begin
                        // speculative read abandoned without a pulse
                        r_state <= MEM_IDLE;
                        r_cool  <= 1'b1;
                        r_wr    <= 1'b0;
                    end else begin
                        if (r_cnt != 3'd0) begin
                            r_rbuf <= w_rbuf_next;
                        end
                        if (r_cnt == r_len) begin
                            r_state <= MEM_IDLE;
                            r_cool  <= 1'b1;
                            if (r_state == MEM_FETCH) begin
                                r_pc_de   <= 1'b1;
                                r_pc_inst <= w_rbuf_next;
                            end else begin
                                r_lsb_de    <= 1'b1;
                                r_lsb_rdata <= w_rbuf_next;
                            end
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                            // hold the address once all bytes are issued so no extra IO read occurs
                            if ((r_cnt + 3'd1) < r_len) begin
                                r_mem_a <= r_mem_a + ADDR_W'(1);
                            end
                        end
                    end
                end
                MEM_STORE: begin
                    // stores ignore flush: a partially written word must not be left behind
                    if (!w_io_stall) begin
                        if (r_cnt == (r_len - 3'd1)) begin
                            r_state  <= MEM_IDLE;
                            r_cool   <= 1'b1;
                            r_wr     <= 1'b0;
                            r_lsb_de <= 1'b1;
                        end else begin
                            r_cnt      <= r_cnt + 3'd1;
                            r_mem_a    <= r_mem_a + ADDR_W'(1);
                            r_mem_dout <= r_wdata[7:0];
                            r_wdata    <= r_wdata >> 8;
                        end
                    end
                end
            endcase
        end
    end

endmodule
